// File: rtl/mem_bus_bridge_if.sv
// Core request/response and memory bus signals of the load/store bridge.
// The slave modport is the bridge's view; master is the core/bus side.
interface mem_bus_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        as_l;
    logic        we_l;
    logic [3:0]  byte_e;
    logic        ram_select_h;
    logic        periph_select_h;
    logic [9:0]  bus_address;
    logic [31:0] bus_data_out;
    logic [31:0] bus_data_in;
    logic        dtack_l;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  bus_data_in, dtack_l,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output as_l, we_l, byte_e, ram_select_h, periph_select_h,
        output bus_address, bus_data_out
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output bus_data_in, dtack_l,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  as_l, we_l, byte_e, ram_select_h, periph_select_h,
        input  bus_address, bus_data_out
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Load/store unit to memory bus bridge: decode, lane steering, strobe cycle, load extend.
// Optional macro BRIDGE_TIMEOUT_EN bounds peripheral strobes to TIMEOUT_CYCLES cycles.
module mem_bus_bridge #(
    parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
    parameter logic [31:0] PERIPH_BASE    = 32'h0002_0000,
    parameter int unsigned RAM_WAIT       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_bridge_if.slave  bus
);

    // Wide enough for both RAM_WAIT (<=15) and the peripheral timeout count.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 16);

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;

    logic               req_ready_q, req_ready_d;
    logic               as_l_q, as_l_d;
    logic               we_l_q, we_l_d;
    logic [3:0]         byte_e_q, byte_e_d;
    logic               ram_sel_q, ram_sel_d;
    logic               per_sel_q, per_sel_d;
    logic [9:0]         baddr_q, baddr_d;
    logic [31:0]        dout_q, dout_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_error_q, rsp_error_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [1:0]         size;
    logic               f3_ok, misalign, ram_hit, per_hit, req_err;
    logic [3:0]         lanes;
    logic [31:0]        steered;
    logic [31:0]        ld_shift, ld_val;
    logic               done, timed_out;

    // Request decode on the live request fields (used only at the accept edge).
    always_comb begin
        f3_ok    = 1'b0;
        lanes    = 4'b0000;
        steered  = 32'h0;
        size     = bus.req_funct3[1:0];
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~bus.req_write;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((size == 2'b01) && bus.req_addr[0]) ||
                   ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        ram_hit  = (bus.req_addr[31:12] == RAM_BASE[31:12]);
        per_hit  = (bus.req_addr[31:12] == PERIPH_BASE[31:12]);
        req_err  = ~f3_ok | misalign | ~(ram_hit | per_hit);
        case (size)
            2'b00:   lanes = 4'b0001 << bus.req_addr[1:0];
            2'b01:   lanes = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        if (bus.req_write) begin
            case (size)
                2'b00:   steered = {4{bus.req_wdata[7:0]}};
                2'b01:   steered = {2{bus.req_wdata[15:0]}};
                default: steered = bus.req_wdata;
            endcase
        end
    end

    // Load data alignment and sign/zero extension.
    always_comb begin
        ld_shift = bus.bus_data_in >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_val = {24'h0, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_val = {16'h0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    // Next state; output registers are loaded with the values for the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        f3_d        = f3_q;
        off_d       = off_q;
        req_ready_d = 1'b0;
        as_l_d      = as_l_q;
        we_l_d      = we_l_q;
        byte_e_d    = byte_e_q;
        ram_sel_d   = ram_sel_q;
        per_sel_d   = per_sel_q;
        baddr_d     = baddr_q;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rdata_d     = rdata_q;
        done        = 1'b0;
        timed_out   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    wr_d  = bus.req_write;
                    f3_d  = bus.req_funct3;
                    off_d = bus.req_addr[1:0];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rdata_d     = 32'h0;
                    end else begin
                        state_d   = ADDR;
                        baddr_d   = bus.req_addr[11:2];
                        ram_sel_d = ram_hit;
                        per_sel_d = per_hit;
                        byte_e_d  = lanes;
                        we_l_d    = ~bus.req_write;
                        dout_d    = steered;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ADDR: begin
                state_d = STROBE;
                as_l_d  = 1'b0;
                cnt_d   = '0;
            end
            STROBE: begin
                if (ram_sel_q) begin
                    if (cnt_q == CNT_W'(RAM_WAIT)) done = 1'b1;
                    else                           cnt_d = cnt_q + CNT_W'(1);
                end else if (!bus.dtack_l) begin
                    done = 1'b1;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (done) begin
                    state_d     = RESP;
                    as_l_d      = 1'b1;
                    we_l_d      = 1'b1;
                    byte_e_d    = 4'b0000;
                    ram_sel_d   = 1'b0;
                    per_sel_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = timed_out;
                    rdata_d     = (wr_q || timed_out) ? 32'h0 : ld_val;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            req_ready_q <= 1'b0;
            as_l_q      <= 1'b1;
            we_l_q      <= 1'b1;
            byte_e_q    <= 4'b0000;
            ram_sel_q   <= 1'b0;
            per_sel_q   <= 1'b0;
            baddr_q     <= 10'h0;
            dout_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            req_ready_q <= req_ready_d;
            as_l_q      <= as_l_d;
            we_l_q      <= we_l_d;
            byte_e_q    <= byte_e_d;
            ram_sel_q   <= ram_sel_d;
            per_sel_q   <= per_sel_d;
            baddr_q     <= baddr_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.as_l            = as_l_q;
    assign bus.we_l            = we_l_q;
    assign bus.byte_e          = byte_e_q;
    assign bus.ram_select_h    = ram_sel_q;
    assign bus.periph_select_h = per_sel_q;
    assign bus.bus_address     = baddr_q;
    assign bus.bus_data_out    = dout_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_error       = rsp_error_q;
    assign bus.rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: transaction model predicts a per-cycle output timeline.
// Build with BRIDGE_TIMEOUT_EN defined to also exercise the peripheral timeout.
module tb_mem_bus_bridge;

    localparam int unsigned TB_WAIT = 1;
    localparam int unsigned TB_TO   = 8;
    localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_bus_bridge_if bus ();

    mem_bus_bridge #(.RAM_WAIT(TB_WAIT), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        as_l;
        logic        we_l;
        logic [3:0]  byte_e;
        logic        ram_sel;
        logic        per_sel;
        logic        bus_chk;
        logic [9:0]  baddr;
        logic [31:0] dout;
        logic        rsp_valid;
        logic        rsp_error;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    bit          chk_en  = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.as_l = 1'b1;
        e.we_l = 1'b1;
        return e;
    endfunction

    // Per-cycle compare against the predicted timeline (idle when nothing is pending).
    always @(negedge clk) begin : cmp
        exp_t e;
        logic rdy;
        if (rst) begin
            exp_q.delete();
            last_rdata = 32'h0;
        end else if (chk_en) begin
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                rdy = 1'b0;
            end else begin
                e   = idle_exp();
                rdy = 1'b1;
            end
            if (e.rsp_valid) last_rdata = e.rdata;
            chk("req_ready", 32'(bus.req_ready), 32'(rdy));
            chk("as_l", 32'(bus.as_l), 32'(e.as_l));
            chk("we_l", 32'(bus.we_l), 32'(e.we_l));
            chk("byte_e", 32'(bus.byte_e), 32'(e.byte_e));
            chk("ram_sel", 32'(bus.ram_select_h), 32'(e.ram_sel));
            chk("per_sel", 32'(bus.periph_select_h), 32'(e.per_sel));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.rsp_valid));
            chk("rsp_error", 32'(bus.rsp_error), 32'(e.rsp_error));
            chk("rsp_rdata", bus.rsp_rdata, last_rdata);
            if (e.bus_chk) begin
                chk("bus_address", 32'(bus.bus_address), 32'(e.baddr));
                chk("bus_data_out", bus.bus_data_out, e.dout);
            end
        end
    end

    // Transaction model: what the bus and response must look like, cycle by cycle.
    task automatic plan(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] bin, input int n);
        exp_t        e;
        int          bytes, s;
        logic [1:0]  a;
        bit          legal, mis, in_ram, in_per, to;
        logic [31:0] mask, v;
        a      = addr[1:0];
        bytes  = 1 << f3[1:0];
        legal  = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis    = (bytes == 2 && a[0]) || (bytes == 4 && a != 2'd0);
        in_ram = (addr >= 32'h0001_0000) && (addr < 32'h0001_1000);
        in_per = (addr >= 32'h0002_0000) && (addr < 32'h0002_1000);
        e = idle_exp();
        if (!legal || mis || !(in_ram || in_per)) begin
            e.rsp_valid = 1'b1;
            e.rsp_error = 1'b1;
            e.rdata     = 32'h0;
            exp_q.push_back(e);
            return;
        end
        e.we_l    = ~w;
        e.byte_e  = 4'(((1 << bytes) - 1) << a);
        e.ram_sel = in_ram;
        e.per_sel = in_per;
        e.bus_chk = 1'b1;
        e.baddr   = addr[11:2];
        if (!w)              e.dout = 32'h0;
        else if (bytes == 1) e.dout = 32'(wdata[7:0]) * 32'h0101_0101;
        else if (bytes == 2) e.dout = 32'(wdata[15:0]) * 32'h0001_0001;
        else                 e.dout = wdata;
        exp_q.push_back(e);
        s  = in_ram ? int'(TB_WAIT) + 1 : n;
        to = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        if (in_per && (n == 0 || n > int'(TB_TO))) begin
            s  = int'(TB_TO);
            to = 1'b1;
        end
`endif
        e.as_l = 1'b0;
        repeat (s) exp_q.push_back(e);
        mask = (bytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * bytes)) - 64'd1);
        v    = (bin >> (8 * a)) & mask;
        if (!f3[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
        e = idle_exp();
        e.rsp_valid = 1'b1;
        e.rsp_error = to;
        e.rdata     = (w || to) ? 32'h0 : v;
        exp_q.push_back(e);
    endtask

    // Issue one request; n>0 pulls Dtack_L low during the n-th strobe cycle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] bin, input int n);
        int budget;
        budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 20) chk("ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_write   = w;
        bus.req_funct3  = f3;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        bus.bus_data_in = bin;
        bus.req_valid   = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        plan(w, f3, addr, wdata, bin, n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1 bus.dtack_l = 1'b0;
            @(posedge clk);
            #1 bus.dtack_l = 1'b1;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.bus_data_in = 32'h0;
        bus.dtack_l     = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_as_l", 32'(bus.as_l), 32'd1);
        chk("rst_we_l", 32'(bus.we_l), 32'd1);
        chk("rst_byte_e", 32'(bus.byte_e), 32'd0);
        chk("rst_ram_sel", 32'(bus.ram_select_h), 32'd0);
        chk("rst_per_sel", 32'(bus.periph_select_h), 32'd0);
        chk("rst_baddr", 32'(bus.bus_address), 32'd0);
        chk("rst_dout", bus.bus_data_out, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
        chk_en = 1'b1;

        // RAM stores and loads
        do_req(1'b1, F_W, 32'h0001_0008, 32'hDEAD_BEEF, 32'h0, 0);
        chk("sw_rdata", bus.rsp_rdata, 32'h0);
        do_req(1'b0, F_B, 32'h0001_0003, 32'h0, 32'h8012_3456, 0);
        chk("lb_rdata", bus.rsp_rdata, 32'hFFFF_FF80);
        do_req(1'b0, F_BU, 32'h0001_0003, 32'h0, 32'h8012_3456, 0);
        chk("lbu_rdata", bus.rsp_rdata, 32'h0000_0080);
        do_req(1'b0, F_HU, 32'h0001_0002, 32'h0, 32'h8012_3456, 0);
        chk("lhu_rdata", bus.rsp_rdata, 32'h0000_8012);
        do_req(1'b0, F_H, 32'h0001_0002, 32'h0, 32'h8000_1234, 0);
        chk("lh_rdata", bus.rsp_rdata, 32'hFFFF_8000);
        do_req(1'b1, F_B, 32'h0001_0001, 32'h0000_00A5, 32'h0, 0);
        do_req(1'b1, F_H, 32'h0001_0002, 32'h1234_BEEF, 32'h0, 0);

        // Error responses: misaligned, unmapped, region edge, illegal funct3
        do_req(1'b0, F_H, 32'h0001_0001, 32'h0, 32'hFFFF_FFFF, 0);
        do_req(1'b0, F_W, 32'h0005_0000, 32'h0, 32'hFFFF_FFFF, 0);
        do_req(1'b0, F_W, 32'h0001_1000, 32'h0, 32'hFFFF_FFFF, 0);
        do_req(1'b0, F_W, 32'h0001_0002, 32'h0, 32'hFFFF_FFFF, 0);
        do_req(1'b1, F_BU, 32'h0001_0000, 32'h55, 32'h0, 0);
        do_req(1'b0, 3'd3, 32'h0001_0000, 32'h0, 32'hFFFF_FFFF, 0);
        chk("err_rdata", bus.rsp_rdata, 32'h0);

        // RAM ignores Dtack_L; last word of the region
        bus.dtack_l = 1'b0;
        do_req(1'b0, F_W, 32'h0001_0FFC, 32'h0, 32'h0BAD_F00D, 0);
        bus.dtack_l = 1'b1;
        chk("lw_top_rdata", bus.rsp_rdata, 32'h0BAD_F00D);

        // Peripheral accesses
        do_req(1'b0, F_W, 32'h0002_0010, 32'h0, 32'hCAFE_F00D, 5);
        chk("per_lw_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        do_req(1'b1, F_B, 32'h0002_0003, 32'h0000_005A, 32'h0, 1);

`ifdef BRIDGE_TIMEOUT_EN
        do_req(1'b0, F_W, 32'h0002_0010, 32'h0, 32'h1111_2222, 0);
        chk("to_rdata", bus.rsp_rdata, 32'h0);
        do_req(1'b0, F_W, 32'h0002_0014, 32'h0, 32'h3333_4444, int'(TB_TO));
        chk("dtack_last_rdata", bus.rsp_rdata, 32'h3333_4444);
`endif

        // Reset in the middle of a peripheral strobe
        chk_en = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = F_W;
        bus.req_addr   = 32'h0002_0010;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_rst_as_l", 32'(bus.as_l), 32'd0);
        rst = 1'b1;
        #1 chk("mid_rst_as_l", 32'(bus.as_l), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst2", 32'(bus.req_ready), 32'd1);
        chk_en = 1'b1;

        do_req(1'b0, F_W, 32'h0001_0000, 32'h0, 32'h0123_4567, 0);
        chk("post_rst_rdata", bus.rsp_rdata, 32'h0123_4567);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the RISC-V core load/store unit and the memory bus, directly upstream of the on-chip SRAM controller.
- Accepts one load/store request at a time over a valid/ready handshake and decodes the address into the RAM or peripheral region.
- Drives the active-low address-strobe and write-enable bus cycle with active-high byte enables.
- Performs byte-lane steering on stores and extract/extend on loads, then returns a single-cycle response.

Parameters:
RAM_BASE, 32'h0001_0000, base of the 4 KB RAM region; match is Addr[31:12]==RAM_BASE[31:12]
PERIPH_BASE, 32'h0002_0000, base of the 4 KB peripheral region; same match rule
RAM_WAIT, 1, extra strobe cycles for RAM accesses (0..15)
TIMEOUT_CYCLES, 64, peripheral strobe limit when the optional feature is enabled

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req_Valid  in  1  core request valid
Req_Ready  out  1  bridge can accept a request
Req_Write  in  1  1=store, 0=load
Req_Funct3  in  3  RISC-V funct3 size/sign code
Req_Addr  in  32  byte address
Req_WData  in  32  store data, right-aligned
Rsp_Valid  out  1  one-cycle response pulse
Rsp_RData  out  32  extended load data; 0 for stores and errors
Rsp_Error  out  1  misaligned, unmapped, illegal funct3 or timeout
AS_L  out  1  address strobe, active low
WE_L  out  1  write enable, active low
Byte_E  out  4  byte-lane enables, active high
RAM_Select_H  out  1  RAM region selected
Periph_Select_H  out  1  peripheral region selected
Bus_Address  out  10  word address, Req_Addr[11:2]
Bus_Data_Out  out  32  lane-steered store data
Bus_Data_In  in  32  read data from the bus
Dtack_L  in  1  peripheral data acknowledge, active low

Behaviour:
- All outputs are registered.
- Reset values: AS_L=1, WE_L=1, Byte_E=0, both selects=0, Bus_Address=0, Bus_Data_Out=0, Rsp_Valid=0, Rsp_RData=0, Rsp_Error=0, Req_Ready=0, state=IDLE.
- Reset asserted mid-cycle aborts the cycle immediately; no response is issued.
- Req_Ready=1 only in IDLE. A request is accepted on a rising edge with Req_Valid&&Req_Ready, and all request fields are latched at that edge.
- State machine:
  - IDLE: on accept, if the access is misaligned (half with Addr[0]=1, word with Addr[1:0]!=0), unmapped, or has an illegal funct3, go to RESP with error and no bus cycle. Otherwise go to ADDR.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - ADDR: drive Bus_Address, select, Byte_E, WE_L=~Req_Write, Bus_Data_Out; AS_L stays 1 (one setup cycle). Next state is STROBE.
  - STROBE (RAM): AS_L=0 for RAM_WAIT+1 cycles. Read data is captured at the edge ending the last strobe cycle. Next state is RESP.
  - STROBE (peripheral): AS_L=0 until Dtack_L=0 is sampled. Data is captured at that edge. Next state is RESP.
  - RESP: AS_L=1, WE_L=1, Byte_E=0, selects=0. Rsp_Valid=1 for exactly one cycle. Next state is IDLE.
- Latency: a RAM access with RAM_WAIT=1 shows Rsp_Valid in the 4th cycle after the accept edge. An error response shows Rsp_Valid in the 1st cycle after the accept edge. Back-to-back requests are accepted at the earliest one cycle after RESP.
- Byte_E by access size:
  - byte: 4'b0001<<Addr[1:0]
  - half: 4'b0011 (Addr[1]=0) or 4'b1100 (Addr[1]=1)
  - word: 4'b1111
- Store data: byte={4{WData[7:0]}}, half={2{WData[15:0]}}, word=WData. Bus_Data_Out=0 during loads.
- Load data: Bus_Data_In >> (8*Addr[1:0]), then:
  - LB: sign-extend from bit 7
  - LBU: zero-extend from bit 7
  - LH: sign-extend from bit 15
  - LHU: zero-extend from bit 15
  - LW: unchanged
- Rsp_RData holds its value until the next RESP or reset.
- Dtack_L is ignored for RAM accesses and outside STROBE.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- Defined: a counter runs during peripheral STROBE. If TIMEOUT_CYCLES strobe cycles pass without Dtack_L=0, AS_L deasserts and the bridge enters RESP with Rsp_Error=1 and Rsp_RData=0. A Dtack_L arriving on the final allowed cycle wins over the timeout.
- Undefined: a peripheral access waits indefinitely for Dtack_L; no counter logic exists.

Test Plan:
- Reset with Clock running: assert Reset, check all reset values. Release Reset: Req_Ready=1 next cycle.
- SW 0x0001_0008 data 0xDEADBEEF: ADDR cycle with Bus_Address=0x002, Byte_E=1111, WE_L=0, AS_L=1. Then 2 strobe cycles with AS_L=0. Then Rsp_Valid=1, Rsp_Error=0, Rsp_RData=0.
- LB 0x0001_0003 with Bus_Data_In=0x80_123456: Byte_E=1000, Rsp_RData=0xFFFFFF80. LBU on the same address gives 0x00000080. LHU 0x0001_0002 gives 0x00008012.
- SB 0x0001_0001 data 0x000000A5: Byte_E=0010, Bus_Data_Out=0xA5A5A5A5.
- LH 0x0001_0001: Rsp_Error=1, Rsp_Valid in 1st cycle after accept, AS_L never low. LW 0x0005_0000 (unmapped) gives the same response.
- Peripheral LW 0x0002_0010 with Dtack_L asserted after 5 strobe cycles: AS_L low 5 cycles and data captured. With BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and Dtack_L held high: Rsp_Error=1 after 8 strobe cycles. Assert Reset during strobe: AS_L=1 immediately and no Rsp_Valid.
